// File: rtl/mini_cpu_pkg.sv
// Shared types and instruction field layout for the mini_cpu slice.
// Word format: [15:12] opcode, [11:8] funct, [7:4] rs, [3:0] rd.
package mini_cpu_pkg;

  localparam int DATA_W  = 16;
  localparam int FLD_W   = 4;
  localparam int OPC_LSB = 12;
  localparam int FN_LSB  = 8;
  localparam int RS_LSB  = 4;
  localparam int RD_LSB  = 0;

  typedef enum logic [3:0] {
    OP_ALU  = 4'h0,
    OP_JMP  = 4'h1,
    OP_BEQZ = 4'h2,
    OP_LDI  = 4'h3,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [3:0] {
    FN_ADD = 4'h0,
    FN_SUB = 4'h1,
    FN_MOV = 4'h2,
    FN_AND = 4'h3,
    FN_OR  = 4'h4,
    FN_XOR = 4'h5
  } funct_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_e;

  // funct 6..F are NOPs and must leave registers and flags untouched
  function automatic logic alu_writes(input logic [3:0] fn);
    return (fn <= FN_XOR);
  endfunction

endpackage

// File: rtl/mini_cpu_alu.sv
// Combinational ALU: result = a op b, where a is R[rd] and b is R[rs].
// carry is the ADD carry-out or the SUB borrow; zero flags a zero result.
module mini_cpu_alu
  import mini_cpu_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  funct,
  output logic [15:0] result,
  output logic        carry,
  output logic        zero
);

  logic [DATA_W:0] wide;

  // a 17-bit subtract leaves the borrow in the top bit when a < b
  always_comb begin
    wide = '0;
    case (funct)
      FN_ADD:  wide = {1'b0, a} + {1'b0, b};
      FN_SUB:  wide = {1'b0, a} - {1'b0, b};
      FN_MOV:  wide = {1'b0, b};
      FN_AND:  wide = {1'b0, a & b};
      FN_OR:   wide = {1'b0, a | b};
      FN_XOR:  wide = {1'b0, a ^ b};
      default: wide = {1'b0, a};
    endcase
    result = wide[DATA_W-1:0];
    carry  = wide[DATA_W];
    zero   = (wide[DATA_W-1:0] == '0);
  end

endmodule

// File: rtl/mini_cpu.sv
// Multi-cycle 16-bit CPU: FETCH latches the opcode word, EXEC consumes the
// optional immediate at the incremented pc, HALT is absorbing until reset.
module mini_cpu
  import mini_cpu_pkg::*;
#(
  parameter int          NREGS    = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] pc,
  output logic [7:0]  mem_addr,
  input  logic [15:0] mem_rdata,
  output logic        halted,
  input  logic [3:0]  dbg_sel,
  output logic [15:0] dbg_data
);

  state_e      state;
  logic [15:0] ir;
  logic [15:0] regs [NREGS];
  logic        z_flag;
  logic        c_flag;

  logic [3:0]  opc;
  logic [3:0]  fn;
  logic [3:0]  rs;
  logic [3:0]  rd;
  logic [15:0] alu_res;
  logic        alu_c;
  logic        alu_z;

  assign opc      = ir[OPC_LSB +: FLD_W];
  assign fn       = ir[FN_LSB  +: FLD_W];
  assign rs       = ir[RS_LSB  +: FLD_W];
  assign rd       = ir[RD_LSB  +: FLD_W];
  assign mem_addr = pc[7:0];
  assign dbg_data = regs[dbg_sel];

  mini_cpu_alu u_alu (
    .a      (regs[rd]),
    .b      (regs[rs]),
    .funct  (fn),
    .result (alu_res),
    .carry  (alu_c),
    .zero   (alu_z)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      halted <= 1'b0;
      z_flag <= 1'b0;
      c_flag <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          ir    <= mem_rdata;
          pc    <= pc + 16'd1;
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          // in EXEC, mem_rdata is the word after the opcode (the immediate)
          case (opc)
            OP_ALU: begin
              if (alu_writes(fn)) begin
                regs[rd] <= alu_res;
                z_flag   <= alu_z;
                if (fn == FN_ADD || fn == FN_SUB) c_flag <= alu_c;
              end
            end
            OP_JMP:  pc <= mem_rdata;
            OP_BEQZ: pc <= (regs[rd] == '0) ? mem_rdata : pc + 16'd1;
            OP_LDI: begin
              regs[rd] <= mem_rdata;
              pc       <= pc + 16'd1;
            end
            OP_HALT: begin
              state  <= HALT;
              halted <= 1'b1;
            end
            default: ;
          endcase
        end
        HALT:    ;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_cpu.sv
// Directed programs for mini_cpu checked against an instruction-level model.
module tb_mini_cpu;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        halted;
  logic [3:0]  dbg_sel;
  logic [15:0] dbg_data;

  logic [15:0] mem [256];
  logic [15:0] prog [$];
  int          total = 0;
  int          bad   = 0;

  // instruction-level model state
  logic [15:0] mr [16];
  logic [15:0] mpc;
  logic        mhalt, mz, mc;

  always #30 clk = ~clk;
  assign mem_rdata = mem[mem_addr];

  mini_cpu #(.NREGS(16), .RESET_PC(16'h0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .halted    (halted),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd_reg(input int r, output logic [15:0] v);
    dbg_sel = r[3:0];
    #1;
    v = dbg_data;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic load(input int base, input logic [15:0] words [$]);
    logic [7:0] a;
    foreach (words[i]) begin
      a = 8'(base + i);
      mem[a] = words[i];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mr[i] = 16'h0000;
    mpc = 16'h0000; mhalt = 1'b0; mz = 1'b0; mc = 1'b0;
  endtask

  // one whole instruction, computed from the ISA rules with plain arithmetic
  task automatic model_step();
    logic [15:0] w, imm, a, b, r;
    int          sum;
    if (!mhalt) begin
      w = mem[mpc[7:0]];
      mpc = mpc + 16'd1;
      imm = mem[mpc[7:0]];
      a = mr[w[3:0]];
      b = mr[w[7:4]];
      case (w[15:12])
        4'h0: begin
          if (w[11:8] <= 4'h5) begin
            case (w[11:8])
              4'h0: begin sum = int'(a) + int'(b); r = 16'(sum); mc = (sum > 65535); end
              4'h1: begin r = 16'(int'(a) - int'(b)); mc = (a < b); end
              4'h2: r = b;
              4'h3: r = a & b;
              4'h4: r = a | b;
              default: r = a ^ b;
            endcase
            mr[w[3:0]] = r;
            mz = (r == 16'h0000);
          end
        end
        4'h1: mpc = imm;
        4'h2: mpc = (a == 16'h0000) ? imm : mpc + 16'd1;
        4'h3: begin mr[w[3:0]] = imm; mpc = mpc + 16'd1; end
        4'hF: mhalt = 1'b1;
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, pc, mpc);
    chk({tag, ".halted"}, {15'd0, halted}, {15'd0, mhalt});
    chk({tag, ".z"}, {15'd0, dut.z_flag}, {15'd0, mz});
    chk({tag, ".c"}, {15'd0, dut.c_flag}, {15'd0, mc});
    for (int r = 0; r < 16; r++) begin
      dbg_sel = r[3:0];
      #1;
      chk($sformatf("%s.R%0d", tag, r), dbg_data, mr[r]);
    end
  endtask

  // called at a negedge: asserts rst, checks the clear happens before any edge
  task automatic reset_cpu();
    rst = 1'b1;
    #2;
    model_reset();
    check_all("async_rst");
    rst = 1'b0;
  endtask

  task automatic run_instrs(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk);
      chk({tag, ".mid_pc"}, pc, mhalt ? mpc : mpc + 16'd1);
      chk({tag, ".mid_halted"}, {15'd0, halted}, {15'd0, mhalt});
      @(posedge clk); @(negedge clk);
      model_step();
      check_all(tag);
    end
  endtask

  logic [15:0] v;

  initial begin
    rst = 1'b1;
    dbg_sel = 4'd0;
    clear_mem();

    // LDI then HALT
    prog = '{16'h3000, 16'h0001, 16'h3001, 16'h0003, 16'hF000};
    load(0, prog);
    @(negedge clk); reset_cpu();
    run_instrs(2, "ldi");
    chk("ldi.pc_lit", pc, 16'h0004);
    rd_reg(0, v); chk("ldi.R0_lit", v, 16'h0001);
    rd_reg(1, v); chk("ldi.R1_lit", v, 16'h0003);
    run_instrs(3, "halt");
    chk("halt.pc_lit", pc, 16'h0005);
    chk("halt.flag_lit", {15'd0, halted}, 16'h0001);

    // ADD with carry-out
    clear_mem();
    prog = '{16'h3000, 16'h0001, 16'h3001, 16'h0003, 16'h0010,
             16'h3002, 16'hFFFF, 16'h0012, 16'hF000};
    load(0, prog);
    @(negedge clk); reset_cpu();
    run_instrs(6, "add");
    rd_reg(0, v); chk("add.R0_lit", v, 16'h0004);
    rd_reg(2, v); chk("add.R2_lit", v, 16'h0002);
    chk("add.c_lit", {15'd0, dut.c_flag}, 16'h0001);

    // SUB borrow, MOV, SUB to zero
    clear_mem();
    prog = '{16'h3000, 16'h0001, 16'h3001, 16'h0003, 16'h0110, 16'h0210,
             16'h3004, 16'h0003, 16'h0114, 16'hF000};
    load(0, prog);
    @(negedge clk); reset_cpu();
    run_instrs(3, "sub");
    rd_reg(0, v); chk("sub.R0_lit", v, 16'hFFFE);
    chk("sub.c_lit", {15'd0, dut.c_flag}, 16'h0001);
    run_instrs(4, "mov");
    rd_reg(0, v); chk("mov.R0_lit", v, 16'h0003);
    rd_reg(4, v); chk("sub0.R4_lit", v, 16'h0000);
    chk("sub0.z_lit", {15'd0, dut.z_flag}, 16'h0001);

    // logic ops and NOPs
    clear_mem();
    prog = '{16'h3006, 16'hF0F0, 16'h3007, 16'h0FF0, 16'h0376, 16'h0476,
             16'h0576, 16'h0976, 16'h5000, 16'hF000};
    load(0, prog);
    @(negedge clk); reset_cpu();
    run_instrs(3, "and");
    rd_reg(6, v); chk("and.R6_lit", v, 16'h00F0);
    run_instrs(6, "logic");
    rd_reg(6, v); chk("xor.R6_lit", v, 16'h0000);

    // branch taken, branch not taken, jump
    clear_mem();
    prog = '{16'h2005, 16'h0010};
    load(0, prog);
    prog = '{16'h3005, 16'h0007, 16'h2005, 16'h0030, 16'h1000, 16'h0020};
    load(16'h10, prog);
    @(negedge clk); reset_cpu();
    run_instrs(1, "beqz_t");
    chk("beqz_t.pc_lit", pc, 16'h0010);
    run_instrs(2, "beqz_nt");
    chk("beqz_nt.pc_lit", pc, 16'h0014);
    run_instrs(3, "jmp");
    chk("jmp.pc_lit", pc, 16'h0021);

    // jump-to-self loop
    clear_mem();
    prog = '{16'h1000, 16'h0000};
    load(0, prog);
    @(negedge clk); reset_cpu();
    run_instrs(3, "loop");
    chk("loop.pc_lit", pc, 16'h0000);

    // LDI split across words 0xFF / 0x00
    clear_mem();
    prog = '{16'h1000, 16'h00FF, 16'hF000};
    load(0, prog);
    prog = '{16'h3003};
    load(16'hFF, prog);
    @(negedge clk); reset_cpu();
    run_instrs(1, "wrapj");
    chk("wrapj.pc_lit", pc, 16'h00FF);
    run_instrs(1, "wrap");
    chk("wrap.pc_lit", pc, 16'h0101);
    rd_reg(3, v); chk("wrap.R3_lit", v, 16'h1000);
    run_instrs(2, "wrap_end");

    // asynchronous reset in the middle of EXEC
    clear_mem();
    prog = '{16'h3000, 16'h0001, 16'h3001, 16'h0003, 16'h3002, 16'h0005, 16'hF000};
    load(0, prog);
    @(negedge clk); reset_cpu();
    run_instrs(2, "pre_rst");
    @(posedge clk); @(negedge clk);
    chk("midexec.pc_lit", pc, 16'h0005);
    reset_cpu();
    run_instrs(4, "post_rst");
    rd_reg(2, v); chk("post_rst.R2_lit", v, 16'h0005);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
